// File: rtl/sn_pkg.sv
// rtl/sn_pkg.sv - shared types and constants for the stochastic-to-binary stage
package sn_pkg;

   // Conversion FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SKIP = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } stb_state_e;

   // Binary width shared with the SNG so both ends agree by default
   localparam int SN_BN_W = 4;

   // Number of samples in one conversion window
   function automatic int win_len(input int win_log2);
      return 1 << win_log2;
   endfunction

endpackage

// File: rtl/sn_win_cnt.sv
// rtl/sn_win_cnt.sv - window and ones counter; STB_BIPOLAR_EN selects signed up/down accumulation
module sn_win_cnt
   import sn_pkg::*;
#(
   parameter int WIN_LOG2 = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       en,
   input  logic                       sn_bit,
`ifdef STB_BIPOLAR_EN
   output logic signed [WIN_LOG2+1:0] acc,
`else
   output logic        [WIN_LOG2:0]   acc,
`endif
   output logic                       done
);

   // Index of the final sample in the window
   localparam logic [WIN_LOG2:0] LAST = (WIN_LOG2+1)'(win_len(WIN_LOG2) - 1);

   logic [WIN_LOG2:0] win_cnt;

   // Count samples taken and accumulate the stream; clear restarts a window
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         win_cnt <= '0;
         acc     <= '0;
      end else if (en) begin
         win_cnt <= win_cnt + 1'b1;
`ifdef STB_BIPOLAR_EN
         acc     <= sn_bit ? acc + 1'b1 : acc - 1'b1;
`else
         acc     <= acc + {{WIN_LOG2{1'b0}}, sn_bit};
`endif
      end
   end

   // The sample being taken this cycle is the last one of the window
   always_comb begin
      done = en && (win_cnt == LAST);
   end

endmodule

// File: rtl/sn_to_bn.sv
// rtl/sn_to_bn.sv - stochastic bitstream to binary converter; optional STB_BIPOLAR_EN decoding
module sn_to_bn
   import sn_pkg::*;
#(
   parameter int BN_W      = SN_BN_W,
   parameter int WIN_LOG2  = 8,
   parameter int START_DLY = 0
) (
   input  logic            i_clk_stb,
   input  logic            i_rst_stb,
   input  logic            i_sn_bit,
   input  logic            i_start_stb,
   input  logic            i_stop_stb,
   output logic [BN_W-1:0] o_x_bn,
   output logic            o_valid_stb,
   output logic            o_busy_stb
);

   localparam int         DLY_W    = (START_DLY > 1) ? $clog2(START_DLY) : 1;
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((START_DLY > 0) ? START_DLY - 1 : 0);
   localparam int         SH       = WIN_LOG2 - BN_W;
   localparam stb_state_e FIRST_ST = (START_DLY > 0) ? SKIP : ACC;

`ifdef STB_BIPOLAR_EN
   localparam logic signed [WIN_LOG2+1:0] POS_MAX = (WIN_LOG2+2)'((1 << (BN_W-1)) - 1);
   logic signed [WIN_LOG2+1:0] acc;
   logic signed [WIN_LOG2+1:0] acc_sh;
`else
   localparam logic [WIN_LOG2:0] UNI_MAX = (WIN_LOG2+1)'((1 << BN_W) - 1);
   logic [WIN_LOG2:0] acc;
   logic [WIN_LOG2:0] acc_sh;
`endif

   stb_state_e      state;
   stb_state_e      next_state;
   logic [DLY_W-1:0] dly_cnt;
   logic            start_go;
   logic            cnt_clr;
   logic            cnt_en;
   logic            win_done;
   logic            busy_d;
   logic            load;
   logic [BN_W-1:0] x_scaled;

   sn_win_cnt #(
      .WIN_LOG2 (WIN_LOG2)
   ) u_win_cnt (
      .clk    (i_clk_stb),
      .rst    (i_rst_stb),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .sn_bit (i_sn_bit),
      .acc    (acc),
      .done   (win_done)
   );

   // State register
   always_ff @(posedge i_clk_stb) begin
      if (i_rst_stb) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; stop beats start, start (re)opens a window from any state
   always_comb begin
      start_go   = i_start_stb && !i_stop_stb;
      next_state = state;
      case (state)
         IDLE: if (start_go) next_state = FIRST_ST;
         SKIP: begin
            if (i_stop_stb)              next_state = IDLE;
            else if (start_go)           next_state = FIRST_ST;
            else if (dly_cnt == DLY_LAST) next_state = ACC;
         end
         ACC: begin
            if (i_stop_stb)    next_state = IDLE;
            else if (start_go) next_state = FIRST_ST;
            else if (win_done) next_state = DONE;
         end
         DONE: next_state = start_go ? FIRST_ST : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode and result scaling
   always_comb begin
      cnt_clr = start_go;
      cnt_en  = (state == ACC);
      busy_d  = (next_state == SKIP) || (next_state == ACC);
      load    = (state == DONE);
`ifdef STB_BIPOLAR_EN
      acc_sh   = acc >>> (SH + 1);
      x_scaled = (acc_sh > POS_MAX) ? POS_MAX[BN_W-1:0] : acc_sh[BN_W-1:0];
`else
      acc_sh   = acc >> SH;
      x_scaled = (acc_sh > UNI_MAX) ? '1 : acc_sh[BN_W-1:0];
`endif
   end

   // Start-delay counter, running only while in SKIP
   always_ff @(posedge i_clk_stb) begin
      if (i_rst_stb || cnt_clr || state != SKIP) begin
         dly_cnt <= '0;
      end else begin
         dly_cnt <= dly_cnt + 1'b1;
      end
   end

   // Registered outputs: result held between windows, one-cycle valid pulse
   always_ff @(posedge i_clk_stb) begin
      if (i_rst_stb) begin
         o_x_bn      <= '0;
         o_valid_stb <= 1'b0;
         o_busy_stb  <= 1'b0;
      end else begin
         o_valid_stb <= load;
         o_busy_stb  <= busy_d;
         if (load) o_x_bn <= x_scaled;
      end
   end

endmodule

// File: tb/tb_sn_to_bn.sv
// tb/tb_sn_to_bn.sv - scoreboard bench for sn_to_bn against a ratio-based reference model
module tb_sn_to_bn;

   localparam int BN_W      = 4;
   localparam int WIN_LOG2  = 8;
   localparam int START_DLY = 0;
   localparam int WIN       = 1 << WIN_LOG2;

   logic            clk = 1'b0;
   logic            rst;
   logic            sn_bit;
   logic            start;
   logic            stop;
   logic [BN_W-1:0] x_bn;
   logic            valid;
   logic            busy;

   always #5 clk = ~clk;

   sn_to_bn #(
      .BN_W      (BN_W),
      .WIN_LOG2  (WIN_LOG2),
      .START_DLY (START_DLY)
   ) dut (
      .i_clk_stb   (clk),
      .i_rst_stb   (rst),
      .i_sn_bit    (sn_bit),
      .i_start_stb (start),
      .i_stop_stb  (stop),
      .o_x_bn      (x_bn),
      .o_valid_stb (valid),
      .o_busy_stb  (busy)
   );

   typedef struct {
      int val;
      int at;
   } exp_t;

   exp_t exp_q[$];
   logic win_bits [WIN];
   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   int   busy_cnt = 0;
   int   t0       = 0;
   int   last_exp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding window
   exp_t e;
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("x_bn", int'(x_bn), e.val);
            check("valid_cycle", cyc, e.at);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_window();
      sn_bit = 1'b0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      t0     = cyc;
      for (int k = 0; k < START_DLY; k++) begin
         sn_bit = 1'($urandom_range(1));
         tick();
      end
   endtask

   task automatic play(input int n);
      for (int k = 0; k < n; k++) begin
         sn_bit = win_bits[k];
         tick();
      end
   endtask

   // Reference: fraction of ones in the window scaled to BN_W bits, capped at full scale
   task automatic finish_window();
      int ones;
      int v;
      exp_t ex;
      ones = 0;
      for (int k = 0; k < WIN; k++) ones += int'(win_bits[k]);
      v = (ones * (1 << BN_W)) / WIN;
      if (v > (1 << BN_W) - 1) v = (1 << BN_W) - 1;
      ex.val   = v;
      ex.at    = t0 + START_DLY + WIN + 1;
      last_exp = v;
      exp_q.push_back(ex);
   endtask

   task automatic do_window();
      start_window();
      play(WIN);
      finish_window();
   endtask

   task automatic fill_density(input int pct);
      for (int k = 0; k < WIN; k++) win_bits[k] = ($urandom_range(99) < pct);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; sn_bit = 1'b0;
      repeat (3) tick();
      check("rst_x_bn", int'(x_bn), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      tick();

      // Saturating all-ones window and busy length
      for (int k = 0; k < WIN; k++) win_bits[k] = 1'b1;
      busy_cnt = 0;
      do_window();
      tick();
      check("busy_len", busy_cnt, WIN);
      repeat (3) tick();

      // Alternating stream, half scale
      for (int k = 0; k < WIN; k++) win_bits[k] = ((k % 2) == 0);
      do_window();
      repeat (3) tick();

      // Stop at sample 100: no pulse, result held
      fill_density(70);
      start_window();
      play(99);
      stop = 1'b1; sn_bit = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_busy", int'(busy), 0);
      repeat (WIN + 10) tick();
      check("stop_hold", int'(x_bn), last_exp);

      // Start and stop together while accumulating: stop wins
      start_window();
      play(30);
      stop = 1'b1; start = 1'b1;
      tick();
      stop = 1'b0; start = 1'b0;
      check("stop_wins_busy", int'(busy), 0);
      repeat (WIN + 5) tick();

      // Restart at sample 50, then 64 ones + 192 zeros
      fill_density(50);
      start_window();
      play(49);
      for (int k = 0; k < WIN; k++) win_bits[k] = (k < 64);
      do_window();
      repeat (3) tick();

      // Reset at sample 120, then a normal conversion
      fill_density(40);
      start_window();
      play(119);
      rst = 1'b1;
      tick();
      check("midrst_x_bn", int'(x_bn), 0);
      check("midrst_valid", int'(valid), 0);
      check("midrst_busy", int'(busy), 0);
      rst = 1'b0;
      last_exp = 0;
      tick();
      fill_density(30);
      do_window();

      // Random windows: back-to-back starts in DONE, stops in DONE, idle gaps
      for (int i = 0; i < 7; i++) begin
         fill_density((i == 0) ? 0 : (i == 1) ? 100 : int'($urandom_range(100)));
         do_window();
         if (i % 3 == 1) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
         end else if (i % 3 == 2) begin
            repeat (int'($urandom_range(5))) tick();
         end
      end

      // Drain outstanding results
      for (int n = 0; n < 400 && exp_q.size() != 0; n++) tick();
      check("drain", exp_q.size(), 0);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sn_to_bn.md
Name: sn_to_bn

Overview:
- Downstream partner of the SNG stage: consumes the stochastic bitstream o_sn_bit and converts it back to a binary number.
- Counts ones over a fixed window of 2^WIN_LOG2 cycles, scales the count to BN_W bits, and presents the result with a one-cycle valid pulse.
- Start/stop control mirrors the SNG, so both stages can be driven from the same controller strobes.

Parameters:
- BN_W, 4, output binary width; must match SNG input width.
- WIN_LOG2, 8, log2 of the window length in cycles; must be >= BN_W.
- START_DLY, 0, cycles skipped after start before the first bit is sampled; aligns with SNG output latency.

Ports:
- i_clk_stb  in  1  clock; all logic on rising edge.
- i_rst_stb  in  1  synchronous, active-high reset.
- i_sn_bit  in  1  stochastic bit from the SNG.
- i_start_stb  in  1  one-cycle pulse that begins a conversion window.
- i_stop_stb  in  1  aborts the current conversion.
- o_x_bn  out  BN_W  converted value; held until the next result.
- o_valid_stb  out  1  one-cycle pulse when o_x_bn updates.
- o_busy_stb  out  1  high while in SKIP or ACC.

Behaviour:
- Reset (sync, active-high): state IDLE, counters 0, o_x_bn=0, o_valid_stb=0, o_busy_stb=0.
- States:
  - IDLE.
  - SKIP: delay counter, up to START_DLY.
  - ACC: window counter of WIN_LOG2+1 bits, ones counter of WIN_LOG2+1 bits.
  - DONE.
- Transitions:
  - IDLE --start--> SKIP when START_DLY>0, else directly to ACC. Counters clear on this edge.
  - SKIP: after START_DLY cycles -> ACC. i_sn_bit is ignored in SKIP.
  - ACC: samples i_sn_bit on every edge, incrementing the ones counter when it is 1. After 2^WIN_LOG2 samples -> DONE.
  - DONE: registers o_x_bn and drives o_valid_stb=1 for exactly one cycle, then -> IDLE.
- Timing: with start sampled at edge t0, samples are taken at edges t0+START_DLY+1 .. t0+START_DLY+2^WIN_LOG2. o_valid_stb is high for the cycle following edge t0+START_DLY+2^WIN_LOG2+1.
- Scaling: o_x_bn = ones >> (WIN_LOG2-BN_W) (truncation). If ones=2^WIN_LOG2, the result saturates to all-ones.
- Stop:
  - i_stop_stb in SKIP or ACC -> IDLE on that edge; no valid pulse, o_x_bn unchanged.
  - Stop in IDLE or DONE is ignored; DONE still emits its pulse.
- Start while busy (SKIP/ACC): the window restarts and counters clear; no pulse is emitted for the aborted window.
- Start in DONE: the pulse is emitted, and the next state is SKIP/ACC instead of IDLE.
- Start and stop in the same cycle: stop wins.
- Reset mid-operation: immediate return to reset values, including o_x_bn=0.
- o_busy_stb is a registered decode of the state (high in SKIP/ACC).

Optional Feature:
- Macro: STB_BIPOLAR_EN.
- Defined:
  - Bipolar decoding; o_x_bn is two's complement.
  - The accumulator is a signed up/down counter: +1 on a 1, -1 on a 0.
  - Result = acc >>> (WIN_LOG2-BN_W+1), saturated to +2^(BN_W-1)-1.
  - All-zeros stream -> -2^(BN_W-1); a 50% stream -> 0.
- Undefined: unipolar ones counter as described above; no up/down logic is synthesized.

Decomposition:
- Package sn_pkg holds:
  - enum stb_state_e {IDLE, SKIP, ACC, DONE};
  - localparam helper for window length (1<<WIN_LOG2);
  - a shared BN_W default, so the SNG and sn_to_bn agree.
- One natural sub-module: sn_win_cnt.
  - Window/ones counter with clear, enable, done flag, and the bipolar variant under the macro.
  - The FSM and scaling stay in the top level.

Test Plan (BN_W=4, WIN_LOG2=8, START_DLY=0):
- Start pulse, i_sn_bit=1 for 256 cycles -> single o_valid_stb, o_x_bn=15 (saturated); busy high for exactly 256 cycles.
- Start pulse, alternating 1/0 stream -> ones=128, o_x_bn=8. With STB_BIPOLAR_EN: o_x_bn=0. All-zeros stream with bipolar: o_x_bn=-8 (4'b1000).
- Prior result 8, new start, stop at sample 100 -> no valid, busy low next cycle, o_x_bn stays 8.
- Start, second start at sample 50, then a stream of 64 ones + 192 zeros after the restart -> one valid, 256 cycles after the second start, o_x_bn=4.
- Reset asserted at sample 120 of a window -> outputs 0 on the next edge, no valid; a following start converts normally.
- START_DLY=2 with the SNG instance upstream, x=4'd5 -> o_x_bn=5±1 after one window; valid at t0+259.
